// File: rtl/vga_frame_reader.sv
// VGA frame reader: 640x480@60 timing that streams an image window from memory port B.
// Optional macro VGA_TEST_PATTERN_EN adds a test_pattern input that overrides window pixels with colour bars.
module vga_frame_reader #(
    parameter int READ_LAT = 2,
    parameter int IMG_W    = 300,
    parameter int IMG_H    = 300,
    parameter int WIN_X0   = 170,
    parameter int WIN_Y0   = 90,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 90300,
`ifdef VGA_TEST_PATTERN_EN
    parameter int BAR_W    = 38,
`endif
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_sel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    input  logic [23:0] read_data_b,
    output logic [17:0] address_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WX0    = 10'(WIN_X0);
    localparam logic [9:0] WX1    = 10'(WIN_X0 + IMG_W - 1);
    localparam logic [9:0] WY0    = 10'(WIN_Y0);
    localparam logic [9:0] WY1    = 10'(WIN_Y0 + IMG_H - 1);
    localparam logic [17:0] SRC_A = 18'(SRC_BASE);
    localparam logic [17:0] DST_A = 18'(DST_BASE);

    // Flag vector carried down the delay line; sync bits are stored active-high
    // so a cleared stage means "not in sync".
    localparam int F_WIN = 0;
    localparam int F_ACT = 1;
    localparam int F_VS  = 2;
    localparam int F_HS  = 3;
`ifdef VGA_TEST_PATTERN_EN
    localparam int FW    = 8;
`else
    localparam int FW    = 4;
`endif

    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          h_last, v_last;
    logic          frame_start_q, frame_start_d;
    logic          sel_q, sel_d;
    logic [17:0]   ptr_q, ptr_d;
    logic [17:0]   addr_hold_q, addr_hold_d;
    logic          win0, last_px;
    logic [FW-1:0] st0;
    logic [FW-1:0] dly_d [READ_LAT];
    logic [FW-1:0] dly_q [READ_LAT];
    logic [FW-1:0] dl;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_n_q, blank_n_d;
    logic [23:0]   rgb_q, rgb_d;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0]    col;
    logic [2:0]    bar;
`endif

    always_comb begin
        h_last        = (h_cnt_q == H_LAST);
        v_last        = (v_cnt_q == V_LAST);
        h_cnt_d       = h_last ? '0 : h_cnt_q + 10'd1;
        v_cnt_d       = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
        end
        frame_start_d = h_last && v_last;
    end

    always_comb begin
        win0         = (h_cnt_q >= WX0) && (h_cnt_q <= WX1) &&
                       (v_cnt_q >= WY0) && (v_cnt_q <= WY1);
        last_px      = (h_cnt_q == WX1) && (v_cnt_q == WY1);
        st0          = '0;
        st0[F_WIN]   = win0;
        st0[F_ACT]   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        st0[F_VS]    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        st0[F_HS]    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
`ifdef VGA_TEST_PATTERN_EN
        col = h_cnt_q - WX0;
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (col >= 10'(k * BAR_W)) bar = 3'(k);
        end
        st0[7]   = test_pattern;
        st0[6:4] = bar;
`endif
    end

    // Running pointer; it stops on the last window pixel so it never leaves the image.
    always_comb begin
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        address_b   = win0 ? ptr_q : addr_hold_q;
        addr_hold_d = address_b;
        if (frame_start_d) begin
            sel_d = frame_sel;
            ptr_d = sel_d ? DST_A : SRC_A;
        end else if (win0 && !last_px) begin
            ptr_d = ptr_q + 18'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign dly_d[gi] = st0;
            end else begin : g_tail
                assign dly_d[gi] = dly_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        dl        = dly_q[READ_LAT-1];
        hsync_d   = ~dl[F_HS];
        vsync_d   = ~dl[F_VS];
        blank_n_d = dl[F_ACT];
        rgb_d     = dl[F_WIN] ? read_data_b : 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
        if (dl[F_WIN] && dl[7]) begin
            case (dl[6:4])
                3'd0:    rgb_d = 24'hFFFFFF;
                3'd1:    rgb_d = 24'hFFFF00;
                3'd2:    rgb_d = 24'h00FFFF;
                3'd3:    rgb_d = 24'h00FF00;
                3'd4:    rgb_d = 24'hFF00FF;
                3'd5:    rgb_d = 24'hFF0000;
                3'd6:    rgb_d = 24'h0000FF;
                default: rgb_d = 24'h000000;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            sel_q         <= 1'b0;
            ptr_q         <= SRC_A;
            addr_hold_q   <= SRC_A;
            for (int i = 0; i < READ_LAT; i++) dly_q[i] <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            addr_hold_q   <= addr_hold_d;
            dly_q         <= dly_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a scaled-down raster (56x37 total, 24x10 window at 8,6)
// so several whole frames fit in a short run; memory model returns data = address after 2 cycles.
module tb_vga_frame_reader;

    localparam int HT = 56;
    localparam int VT = 37;
    localparam int FR = HT * VT;   // 2072 cycles per frame

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_sel = 1'b0;
    logic [23:0] read_data_b = '0;
    logic [17:0] address_b;
    logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [17:0] mem_addr_q = '0;
    logic [24:0] pix;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #20 clk = ~clk;

    always @(posedge clk) begin
        mem_addr_q  <= address_b;
        read_data_b <= {6'd0, mem_addr_q};
    end

    assign pix = {vga_blank_n, vga_r, vga_g, vga_b};

    vga_frame_reader #(
        .READ_LAT(2), .IMG_W(24), .IMG_H(10), .WIN_X0(8), .WIN_Y0(6),
        .SRC_BASE(0), .DST_BASE(1000),
`ifdef VGA_TEST_PATTERN_EN
        .BAR_W(3),
`endif
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_sel(frame_sel),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .read_data_b(read_data_b),
        .address_b(address_b),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
        chk({tag, "_pix"}, 32'(pix), 32'd0);
        chk({tag, "_addr"}, 32'(address_b), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int fs_cnt, fs_at, hs_low, vs_low, first_hs, first_vs, blank_hi, nz, good_lines;
        int sum, amax;
        int line_bh [VT];

        // Reset and check reset state.
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        cyc = 0;

        // Frame 1: statistics over one frame of output plus directed pixel/address points.
        fs_cnt = 0; fs_at = -1; hs_low = 0; vs_low = 0; first_hs = -1; first_vs = -1;
        blank_hi = 0; nz = 0; sum = 0; amax = 0;
        for (int i = 0; i < VT; i++) line_bh[i] = 0;
        while (cyc < FR + 2) begin
            step();
            if (frame_start) begin fs_cnt++; fs_at = cyc; end
            if (cyc < FR && int'(address_b) > amax) amax = int'(address_b);
            if (cyc >= 3) begin
                if (!vga_hsync) begin hs_low++; if (first_hs < 0) first_hs = cyc; end
                if (!vga_vsync) begin vs_low++; if (first_vs < 0) first_vs = cyc; end
                if (vga_blank_n) begin blank_hi++; line_bh[(cyc - 3) / HT]++; end
                sum += int'({vga_r, vga_g, vga_b});
                if ({vga_r, vga_g, vga_b} != 24'd0) nz++;
            end
            if (cyc == 3)   chk("f1_pix_h0",       32'(pix), 32'h1000000);
            if (cyc == 43)  chk("f1_pix_h40",      32'(pix), 32'h0);
            if (cyc == 344) chk("f1_addr_first",   32'(address_b), 32'd0);
            if (cyc == 345) chk("f1_addr_second",  32'(address_b), 32'd1);
            if (cyc == 346) chk("f1_pix_border_l", 32'(pix), 32'h1000000);
            if (cyc == 347) chk("f1_pix_first",    32'(pix), 32'h1000000);
            if (cyc == 348) chk("f1_pix_second",   32'(pix), 32'h1000001);
            if (cyc == 871) chk("f1_addr_last",    32'(address_b), 32'd239);
            if (cyc == 872) chk("f1_addr_hold",    32'(address_b), 32'd239);
            if (cyc == 874) chk("f1_pix_last",     32'(pix), 32'h10000EF);
            if (cyc == 875) chk("f1_pix_border_r", 32'(pix), 32'h1000000);
        end
        good_lines = 0;
        for (int i = 0; i < VT; i++) begin
            if (line_bh[i] == ((i < 30) ? 40 : 0)) good_lines++;
        end
        chk("f1_frame_start_count", 32'(fs_cnt), 32'd1);
        chk("f1_frame_start_at",    32'(fs_at), 32'(FR));
        chk("f1_hsync_low_total",   32'(hs_low), 32'd222);
        chk("f1_hsync_first_low",   32'(first_hs), 32'd47);
        chk("f1_vsync_low_total",   32'(vs_low), 32'd112);
        chk("f1_vsync_first_low",   32'(first_vs), 32'd1795);
        chk("f1_blank_high_total",  32'(blank_hi), 32'd1200);
        chk("f1_blank_lines_ok",    32'(good_lines), 32'(VT));
        chk("f1_pixel_sum",         32'(sum), 32'd28680);
        chk("f1_pixel_nonzero",     32'(nz), 32'd239);
        chk("f1_addr_max",          32'(amax), 32'd239);

        // Frame 2: frame_sel rises mid-frame, the frame must finish on source addresses.
        run_to(FR + 10 * HT);
        frame_sel = 1'b1;
        amax = 0;
        while (cyc < 2 * FR - 1) begin
            step();
            if (int'(address_b) > amax) amax = int'(address_b);
            if (cyc == FR + 874) chk("f2_pix_last_src", 32'(pix), 32'h10000EF);
        end
        chk("f2_addr_max_src", 32'(amax), 32'd239);

        // Frame 3: destination buffer.
        run_to(2 * FR + 344);
        chk("f3_addr_first_dst", 32'(address_b), 32'd1000);
        run_to(2 * FR + 347);
        chk("f3_pix_first_dst", 32'(pix), 32'h10003E8);
        amax = 0;
        while (cyc < 3 * FR - 1) begin
            step();
            if (int'(address_b) > amax) amax = int'(address_b);
            if (cyc == 2 * FR + 872) chk("f3_addr_hold_dst", 32'(address_b), 32'd1239);
        end
        chk("f3_addr_max_dst", 32'(amax), 32'd1239);

        // frame_sel falls exactly on the boundary cycle: that value must be used.
        frame_sel = 1'b0;
        run_to(3 * FR);
        chk("f4_frame_start", 32'(frame_start), 32'd1);
        run_to(3 * FR + 344);
        chk("f4_addr_first_src", 32'(address_b), 32'd0);

        // Mid-frame reset at h=20, v=12 while frame_sel is high.
        run_to(3 * FR + 12 * HT + 20);
        chk("f4_addr_midwindow", 32'(address_b), 32'd156);
        rst = 1'b1;
        frame_sel = 1'b1;
        step();
        chk_reset("midrst");
        rst = 1'b0;
        cyc = 0;
        fs_at = -1;
        while (fs_at < 0 && cyc < FR + 100) begin
            step();
            if (cyc == 344) chk("postrst_addr_first", 32'(address_b), 32'd0);
            if (frame_start) fs_at = cyc;
        end
        chk("postrst_frame_start_at", 32'(fs_at), 32'(FR));

`ifdef VGA_TEST_PATTERN_EN
        test_pattern = 1'b1;
        run_to(FR + 347);
        chk("tp_col0",  32'(pix), 32'h1FFFFFF);
        run_to(FR + 350);
        chk("tp_col3",  32'(pix), 32'h1FFFF00);
        run_to(FR + 365);
        chk("tp_col18", 32'(pix), 32'h10000FF);
        run_to(FR + 370);
        chk("tp_col23", 32'(pix), 32'h1000000);
        chk("tp_addr_advances", 32'(address_b), 32'd1023);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
